// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch/decode definitions: NOP encoding, opcode fields,
// branch opcode patterns, PC indexing and fetch FSM state encodings.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] NOP         = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 27;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int IMM_SIGN = 15;
    localparam int PC_INDEX = 2;

    localparam logic [4:0] OPC_COND_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_CALL        = 5'b11011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_HOLD    = 2'd2,
        ST_SQUASH  = 2'd3
    } fetch_state_e;

    function automatic logic is_cond_branch(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OPC_COND_BRANCH;
    endfunction

    function automatic logic [31:0] sext_imm(input logic [31:0] instr);
        return {{16{instr[IMM_SIGN]}}, instr[IMM_MSB:IMM_LSB]};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_predictor.sv
// Static branch predictor: backward conditional branches predicted taken.
// Ports: instr_i/pc_i in; predict_taken_o, target_o (next fetch address) out.
module static_branch_predictor
    import instruction_fetch_unit_pkg::*;
#(
    parameter bit PREDICT_ENABLE = 1'b1
) (
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        predict_taken_o,
    output logic [31:0] target_o
);

    logic [31:0] seq_pc;

    assign seq_pc = pc_i + INSTR_BYTES;

    // A negative displacement (sign bit set) marks a backward branch.
    assign predict_taken_o = PREDICT_ENABLE
                          && is_cond_branch(instr_i)
                          && instr_i[IMM_SIGN];

    assign target_o = predict_taken_o ? seq_pc + sext_imm(instr_i)
                                      : seq_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: req/ack memory fetch, static prediction, flush
// redirect, stall hold buffer. Ports: clock_i, reset_i; iaddress_o,
// iaccess_o, idata_i, iack_i (memory); instruction_o, pc_o,
// branch_predicted_o, stall_i (decode); flush_i, restart_pc_i (execute).
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter bit          PREDICT_ENABLE = 1'b1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    output logic [31:0] iaddress_o,
    output logic        iaccess_o,
    input  logic [31:0] idata_i,
    input  logic        iack_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        branch_predicted_o,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] restart_pc_i
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  squash_pc_q, squash_pc_d;

    logic         hold_en;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic         hold_pred_q, hold_pred_d;

    logic         out_en;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_q, pc_d;
    logic         pred_q, pred_d;

    logic         bp_taken;
    logic [31:0]  bp_target;
    logic [31:0]  fetch_pc_plus4;

    static_branch_predictor #(
        .PREDICT_ENABLE (PREDICT_ENABLE)
    ) u_predictor (
        .instr_i         (idata_i),
        .pc_i            (fetch_pc_q),
        .predict_taken_o (bp_taken),
        .target_o        (bp_target)
    );

    assign fetch_pc_plus4 = fetch_pc_q + INSTR_BYTES;

    assign hold_instr_d = idata_i;
    assign hold_pc_d    = fetch_pc_plus4;
    assign hold_pred_d  = bp_taken;

    // While squashing, the abandoned request keeps its address until
    // memory acknowledges it; fetch_pc already holds the redirect target.
    assign iaccess_o  = (state_q == ST_REQUEST) || (state_q == ST_SQUASH);
    assign iaddress_o = (state_q == ST_SQUASH) ? squash_pc_q : fetch_pc_q;

    assign instruction_o      = instr_q;
    assign pc_o               = pc_q;
    assign branch_predicted_o = pred_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        squash_pc_d = squash_pc_q;
        hold_en     = 1'b0;
        out_en      = 1'b0;
        instr_d     = NOP;
        pc_d        = pc_q;
        pred_d      = 1'b0;

        if (flush_i) begin
            out_en     = 1'b1;
            fetch_pc_d = restart_pc_i;
            unique case (state_q)
                ST_REQUEST: begin
                    if (iack_i) begin
                        state_d = ST_REQUEST;
                    end else begin
                        state_d     = ST_SQUASH;
                        squash_pc_d = fetch_pc_q;
                    end
                end
                ST_SQUASH: state_d = iack_i ? ST_REQUEST : ST_SQUASH;
                default:   state_d = ST_REQUEST;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_REQUEST;
                ST_REQUEST: begin
                    if (iack_i) begin
                        fetch_pc_d = bp_target;
                        if (stall_i) begin
                            hold_en = 1'b1;
                            state_d = ST_HOLD;
                        end else begin
                            out_en  = 1'b1;
                            instr_d = idata_i;
                            pc_d    = fetch_pc_plus4;
                            pred_d  = bp_taken;
                        end
                    end else if (!stall_i) begin
                        // Decode took the last word and nothing new
                        // arrived: present a bubble, not a duplicate.
                        out_en = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        out_en  = 1'b1;
                        instr_d = hold_instr_q;
                        pc_d    = hold_pc_q;
                        pred_d  = hold_pred_q;
                        state_d = ST_REQUEST;
                    end
                end
                ST_SQUASH: begin
                    out_en = !stall_i;
                    if (iack_i) begin
                        state_d = ST_REQUEST;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            squash_pc_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            squash_pc_q <= squash_pc_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            hold_pred_q  <= 1'b0;
        end else if (hold_en) begin
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_pred_q  <= hold_pred_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            instr_q <= NOP;
            pc_q    <= '0;
            pred_q  <= 1'b0;
        end else if (out_en) begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pred_q  <= pred_d;
        end
    end

endmodule
